hub75_bcm_scan_driver: RTL and testbench

- Parametrised HUB-75 panel scan engine; successor to the single-bit 64x64 driver.
- Reads pixel colour from an external frame-buffer read port and shifts two half-panels (top/bottom) per row.
- Binary-coded modulation (BCM) over COLOR_BITS bit planes gives per-channel intensity.
- Sits between the frame buffer and the panel connector pins; display of plane n overlaps shifting of plane n+1.

---
 rtl/hub75_pkg.sv | 36 +++
 rtl/hub75_bcm_timer.sv | 48 ++++
 rtl/hub75_bcm_scan_driver.sv | 231 +++++++++++++++++++++++
 tb/tb_hub75_bcm_scan_driver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hub75_pkg
// Purpose : Shared types and helpers for the HUB-75 BCM scan engine: scan
//           state encoding, colour-channel slot indices and width helpers.
// Revision: 1.0 - initial release
// ============================================================================
package hub75_pkg;

  // Scan engine states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WAIT  = 3'd2,
    ST_BLANK = 3'd3,
    ST_LATCH = 3'd4
  } scan_state_e;

  // Channel slot inside a {R,G,B} pixel word; multiply by COLOR_BITS for
  // the bit offset of the channel's LSB.
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  // Address width that never collapses to zero bits for tiny ranges.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  // Width of the oe down-counter: must hold OE_BASE << (COLOR_BITS-1).
  function automatic int timer_width(input int oe_base, input int color_bits);
    return $clog2(oe_base << (color_bits - 1)) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hub75_bcm_timer.sv
`default_nettype none
// ============================================================================
// Module  : hub75_bcm_timer
// Purpose : Loadable down-counter that holds the panel output enable low
//           (active) while non-zero and flags when the display slot is over.
// Revision: 1.0 - initial release
// ============================================================================
module hub75_bcm_timer #(
  parameter int TIMER_W = 4
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               oe_o,
  output logic               zero_o
);

  logic [TIMER_W-1:0] count_q, count_d;
  logic               oe_q, oe_d;

  // Load has priority; otherwise count down and stick at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
    oe_d = (count_d == '0);
  end

  // Counter and registered (glitch-free) active-low enable.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
      oe_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      oe_q    <= oe_d;
    end
  end

  assign oe_o   = oe_q;
  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/hub75_bcm_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : hub75_bcm_scan_driver
// Purpose : HUB-75 scan engine with binary-coded modulation. Fetches pixels
//           from a frame-buffer read port, shifts one bit plane of the top
//           and bottom half-rows, blanks, latches, and displays the plane
//           for OE_BASE<<plane cycles while the next plane is shifted.
// Revision: 1.0 - initial release
// ============================================================================
module hub75_bcm_scan_driver
  import hub75_pkg::*;
#(
  parameter  int WIDTH        = 64,
  parameter  int HEIGHT       = 64,
  parameter  int COLOR_BITS   = 8,
  parameter  int CLK_DIV      = 2,
  parameter  int OE_BASE      = 8,
  parameter  int BLANK_CYCLES = 4,
  localparam int X_W          = clog2_min1(WIDTH),
  localparam int ROW_W        = clog2_min1(HEIGHT / 2),
  localparam int RGB_W        = 3 * COLOR_BITS
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  output logic [X_W-1:0]   pix_x_o,
  output logic [ROW_W-1:0] pix_row_o,
  input  logic [RGB_W-1:0] pix_rgb_top_i,
  input  logic [RGB_W-1:0] pix_rgb_bot_i,
  output logic             r1_o,
  output logic             g1_o,
  output logic             b1_o,
  output logic             r2_o,
  output logic             g2_o,
  output logic             b2_o,
  output logic             clk_o,
  output logic             lat_o,
  output logic             oe_o,
  output logic [ROW_W-1:0] row_addr_o,
  output logic             frame_done_o
);

  localparam int PL_W  = clog2_min1(COLOR_BITS);
  localparam int PH_W  = clog2_min1(2 * CLK_DIV);
  localparam int BL_W  = clog2_min1(BLANK_CYCLES);
  localparam int TMR_W = timer_width(OE_BASE, COLOR_BITS);

  localparam logic [PH_W-1:0]  C_PH_SAMPLE = PH_W'(1);
  localparam logic [PH_W-1:0]  C_PH_RISE   = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  C_PH_LAST   = PH_W'(2 * CLK_DIV - 1);
  localparam logic [X_W-1:0]   C_X_LAST    = X_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST  = ROW_W'(HEIGHT / 2 - 1);
  localparam logic [PL_W-1:0]  C_PL_LAST   = PL_W'(COLOR_BITS - 1);
  localparam logic [BL_W-1:0]  C_BL_LAST   = BL_W'(BLANK_CYCLES - 1);
  localparam logic [TMR_W-1:0] C_OE_BASE   = TMR_W'(OE_BASE);

  scan_state_e      state_q, state_d;
  logic [PL_W-1:0]  plane_q, plane_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [BL_W-1:0]  blank_q, blank_d;
  logic             clk_q, clk_d;
  logic             lat_q, lat_d;
  logic [5:0]       data_q, data_d;     // {r1,g1,b1,r2,g2,b2}
  logic [ROW_W-1:0] row_addr_q, row_addr_d;
  logic             frame_done_q, frame_done_d;

  logic [COLOR_BITS-1:0] w_top_r, w_top_g, w_top_b;
  logic [COLOR_BITS-1:0] w_bot_r, w_bot_g, w_bot_b;
  logic                  w_tmr_load;
  logic [TMR_W-1:0]      w_tmr_val;
  logic                  w_tmr_zero;
  logic                  w_oe;

  assign w_top_r = pix_rgb_top_i[CH_R*COLOR_BITS +: COLOR_BITS];
  assign w_top_g = pix_rgb_top_i[CH_G*COLOR_BITS +: COLOR_BITS];
  assign w_top_b = pix_rgb_top_i[CH_B*COLOR_BITS +: COLOR_BITS];
  assign w_bot_r = pix_rgb_bot_i[CH_R*COLOR_BITS +: COLOR_BITS];
  assign w_bot_g = pix_rgb_bot_i[CH_G*COLOR_BITS +: COLOR_BITS];
  assign w_bot_b = pix_rgb_bot_i[CH_B*COLOR_BITS +: COLOR_BITS];

  // Display slot of the just-latched plane starts the cycle after LATCH.
  assign w_tmr_load = (state_q == ST_LATCH);
  assign w_tmr_val  = C_OE_BASE << plane_q;

  hub75_bcm_timer #(
    .TIMER_W (TMR_W)
  ) u_timer (
    .clock_i    (clock_i),
    .reset_ni   (reset_ni),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .oe_o       (w_oe),
    .zero_o     (w_tmr_zero)
  );

  // Next-state and output logic of the scan sequencer.
  always_comb begin
    state_d      = state_q;
    plane_d      = plane_q;
    row_d        = row_q;
    x_d          = x_q;
    phase_d      = phase_q;
    blank_d      = blank_q;
    clk_d        = 1'b0;
    data_d       = data_q;
    row_addr_d   = row_addr_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_SHIFT;
          plane_d = '0;
          row_d   = '0;
          x_d     = '0;
          phase_d = '0;
        end
      end

      ST_SHIFT: begin
        // Panel clk is registered, so it lags the phase count by one cycle;
        // this keeps captured data ahead of (or, at CLK_DIV=1, with) the rise.
        clk_d = (phase_q >= C_PH_RISE);
        // Frame-buffer data for pix_x is valid one cycle after the address.
        if (phase_q == C_PH_SAMPLE) begin
          data_d = {w_top_r[plane_q], w_top_g[plane_q], w_top_b[plane_q],
                    w_bot_r[plane_q], w_bot_g[plane_q], w_bot_b[plane_q]};
        end
        if (phase_q == C_PH_LAST) begin
          phase_d = '0;
          if (x_q == C_X_LAST) begin
            x_d     = '0;
            state_d = ST_WAIT;
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_WAIT: begin
        // Previous plane must finish displaying before the latch overwrites it.
        if (w_tmr_zero) begin
          state_d = ST_BLANK;
          blank_d = '0;
        end
      end

      ST_BLANK: begin
        if (blank_q == '0) begin
          row_addr_d = row_q;
        end
        if (blank_q == C_BL_LAST) begin
          state_d = ST_LATCH;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end

      ST_LATCH: begin
        if (plane_q != C_PL_LAST) begin
          plane_d = plane_q + 1'b1;
          state_d = ST_SHIFT;
        end else begin
          plane_d = '0;
          if (row_q == C_ROW_LAST) begin
            row_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
          // Enable is only honoured here, at a row boundary.
          state_d = enable_i ? ST_SHIFT : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Latch strobe is registered alongside the state that owns it.
    lat_d = (state_d == ST_LATCH);
  end

  // State and output registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_IDLE;
      plane_q      <= '0;
      row_q        <= '0;
      x_q          <= '0;
      phase_q      <= '0;
      blank_q      <= '0;
      clk_q        <= 1'b0;
      lat_q        <= 1'b0;
      data_q       <= '0;
      row_addr_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      plane_q      <= plane_d;
      row_q        <= row_d;
      x_q          <= x_d;
      phase_q      <= phase_d;
      blank_q      <= blank_d;
      clk_q        <= clk_d;
      lat_q        <= lat_d;
      data_q       <= data_d;
      row_addr_q   <= row_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_x_o      = x_q;
  assign pix_row_o    = row_q;
  assign r1_o         = data_q[5];
  assign g1_o         = data_q[4];
  assign b1_o         = data_q[3];
  assign r2_o         = data_q[2];
  assign g2_o         = data_q[1];
  assign b2_o         = data_q[0];
  assign clk_o        = clk_q;
  assign lat_o        = lat_q;
  assign oe_o         = w_oe;
  assign row_addr_o   = row_addr_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hub75_bcm_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_hub75_bcm_scan_driver
// Purpose : Directed bench for the HUB-75 BCM scan engine. Instance A runs
//           a 4x4, 2-plane panel with OE_BASE=2; instance B uses OE_BASE=64
//           so display is longer than shifting.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hub75_bcm_scan_driver;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- DUT A ----------------
  logic       a_rst_n, a_en;
  logic [1:0] a_x;
  logic [0:0] a_row, a_ra;
  logic [5:0] top_rgb, a_bot_q;
  logic       a_r1, a_g1, a_b1, a_r2, a_g2, a_b2, a_clk, a_lat, a_oe, a_fd;

  hub75_bcm_scan_driver #(
    .WIDTH(4), .HEIGHT(4), .COLOR_BITS(2), .CLK_DIV(1), .OE_BASE(2), .BLANK_CYCLES(4)
  ) u_dut_a (
    .clock_i(clock), .reset_ni(a_rst_n), .enable_i(a_en),
    .pix_x_o(a_x), .pix_row_o(a_row),
    .pix_rgb_top_i(top_rgb), .pix_rgb_bot_i(a_bot_q),
    .r1_o(a_r1), .g1_o(a_g1), .b1_o(a_b1), .r2_o(a_r2), .g2_o(a_g2), .b2_o(a_b2),
    .clk_o(a_clk), .lat_o(a_lat), .oe_o(a_oe), .row_addr_o(a_ra), .frame_done_o(a_fd)
  );

  // Registered frame buffer: bottom pixel = {R=x, G=0, B=~x}
  always @(posedge clock) a_bot_q <= {a_x, 2'b00, ~a_x};

  // ---------------- DUT B ----------------
  logic       b_rst_n, b_en;
  logic [1:0] b_x;
  logic [0:0] b_row, b_ra;
  logic [5:0] b_bot;
  logic       b_r1, b_g1, b_b1, b_r2, b_g2, b_b2, b_clk, b_lat, b_oe, b_fd;

  hub75_bcm_scan_driver #(
    .WIDTH(4), .HEIGHT(4), .COLOR_BITS(2), .CLK_DIV(1), .OE_BASE(64), .BLANK_CYCLES(4)
  ) u_dut_b (
    .clock_i(clock), .reset_ni(b_rst_n), .enable_i(b_en),
    .pix_x_o(b_x), .pix_row_o(b_row),
    .pix_rgb_top_i(top_rgb), .pix_rgb_bot_i(b_bot),
    .r1_o(b_r1), .g1_o(b_g1), .b1_o(b_b1), .r2_o(b_r2), .g2_o(b_g2), .b2_o(b_b2),
    .clk_o(b_clk), .lat_o(b_lat), .oe_o(b_oe), .row_addr_o(b_ra), .frame_done_o(b_fd)
  );

  // ---------------- Monitor A (samples on falling edge) ----------------
  logic [31:0] a_r1v, a_b1v, a_r2v, a_b2v;
  int          a_rise, a_lat_n, a_fd_n, a_lat_at_fd, a_rise_at_fd;
  int          a_run, a_runs, a_viol, a_bviol;
  int          a_lat_row [16];
  int          a_oe_len  [16];
  logic        a_clk_prev;
  logic [3:0]  a_oe_hist;

  always @(negedge clock) begin
    if (!a_rst_n) begin
      a_r1v = '0; a_b1v = '0; a_r2v = '0; a_b2v = '0;
      a_rise = 0; a_lat_n = 0; a_fd_n = 0; a_lat_at_fd = -1; a_rise_at_fd = -1;
      a_run = 0; a_runs = 0; a_viol = 0; a_bviol = 0;
      a_clk_prev = 1'b0; a_oe_hist = 4'hF;
      for (int i = 0; i < 16; i++) begin a_lat_row[i] = -1; a_oe_len[i] = -1; end
    end else begin
      if (a_clk && !a_clk_prev) begin
        if (a_rise < 32) begin
          a_r1v[a_rise] = a_r1; a_b1v[a_rise] = a_b1;
          a_r2v[a_rise] = a_r2; a_b2v[a_rise] = a_b2;
        end
        a_rise++;
      end
      if (a_lat) begin
        if (a_lat_n < 16) a_lat_row[a_lat_n] = int'(a_ra);
        a_lat_n++;
        if (!a_oe) a_viol++;
        if ({a_oe_hist, a_oe} != 5'b11111) a_bviol++;
      end
      if (a_fd) begin
        if (a_fd_n == 0) begin a_lat_at_fd = a_lat_n; a_rise_at_fd = a_rise; end
        a_fd_n++;
      end
      if (!a_oe) a_run++;
      else if (a_run > 0) begin
        if (a_runs < 16) a_oe_len[a_runs] = a_run;
        a_runs++; a_run = 0;
      end
      a_oe_hist  = {a_oe_hist[2:0], a_oe};
      a_clk_prev = a_clk;
    end
  end

  // ---------------- Monitor B ----------------
  int         b_cyc, b_lat_n, b_run, b_runs, b_viol, b_bviol;
  int         b_lat_t  [8];
  int         b_oe_len [8];
  logic [3:0] b_oe_hist;

  always @(negedge clock) begin
    if (!b_rst_n) begin
      b_cyc = 0; b_lat_n = 0; b_run = 0; b_runs = 0; b_viol = 0; b_bviol = 0;
      b_oe_hist = 4'hF;
      for (int i = 0; i < 8; i++) begin b_lat_t[i] = -1; b_oe_len[i] = -1; end
    end else begin
      b_cyc++;
      if (b_lat) begin
        if (b_lat_n < 8) b_lat_t[b_lat_n] = b_cyc;
        b_lat_n++;
        if (!b_oe) b_viol++;
        if ({b_oe_hist, b_oe} != 5'b11111) b_bviol++;
      end
      if (!b_oe) b_run++;
      else if (b_run > 0) begin
        if (b_runs < 8) b_oe_len[b_runs] = b_run;
        b_runs++; b_run = 0;
      end
      b_oe_hist = {b_oe_hist[2:0], b_oe};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // ---------------- Directed sequence ----------------
  initial begin
    int guard;
    a_rst_n = 1'b0; b_rst_n = 1'b0; a_en = 1'b0; b_en = 1'b0;
    top_rgb = 6'b10_00_01;   // R=2, G=0, B=1
    b_bot   = 6'b00_00_00;
    step(3);

    // Reset values
    chk("rst_clk", a_clk, 0);
    chk("rst_lat", a_lat, 0);
    chk("rst_oe", a_oe, 1);
    chk("rst_data", {a_r1, a_g1, a_b1, a_r2, a_g2, a_b2}, 0);
    chk("rst_row_addr", a_ra, 0);
    chk("rst_pix_x", a_x, 0);
    chk("rst_pix_row", a_row, 0);
    chk("rst_frame_done", a_fd, 0);

    // One full frame on A, B running alongside
    a_rst_n = 1'b1; a_en = 1'b1; b_rst_n = 1'b1; b_en = 1'b1;
    guard = 0;
    while (a_fd_n == 0 && guard < 300) begin step(1); guard++; end
    chk("frame_done_seen", (a_fd_n != 0) ? 1 : 0, 1);
    step(8);
    chk("p0_r1", a_r1v[3:0], 4'b0000);
    chk("p0_b1", a_b1v[3:0], 4'b1111);
    chk("p0_r2", a_r2v[3:0], 4'b1010);
    chk("p0_b2", a_b2v[3:0], 4'b0101);
    chk("p1_r1", a_r1v[7:4], 4'b1111);
    chk("p1_b1", a_b1v[7:4], 4'b0000);
    chk("p1_r2", a_r2v[7:4], 4'b1100);
    chk("p1_b2", a_b2v[7:4], 4'b0011);
    chk("rises_per_frame", a_rise_at_fd, 16);
    chk("lat_per_frame", a_lat_at_fd, 4);
    chk("frame_done_width", a_fd_n, 1);
    chk("lat_row0", a_lat_row[0], 0);
    chk("lat_row1", a_lat_row[1], 0);
    chk("lat_row2", a_lat_row[2], 1);
    chk("lat_row3", a_lat_row[3], 1);
    chk("oe_len0", a_oe_len[0], 2);
    chk("oe_len1", a_oe_len[1], 4);
    chk("oe_len2", a_oe_len[2], 2);
    chk("oe_len3", a_oe_len[3], 4);
    chk("a_lat_with_oe_low", a_viol, 0);
    chk("a_oe_low_in_blank", a_bviol, 0);

    // Long display (B): WAIT must hold until the timer expires
    guard = 0;
    while (b_lat_n < 3 && guard < 400) begin step(1); guard++; end
    chk("b_three_lats", (b_lat_n >= 3) ? 1 : 0, 1);
    chk("b_lat_gap0", b_lat_t[1] - b_lat_t[0], 70);
    chk("b_lat_gap1", b_lat_t[2] - b_lat_t[1], 134);
    chk("b_oe_len0", b_oe_len[0], 64);
    chk("b_oe_len1", b_oe_len[1], 128);
    chk("b_lat_with_oe_low", b_viol, 0);
    chk("b_oe_low_in_blank", b_bviol, 0);
    b_en = 1'b0;

    // Enable dropped during plane 0 of row 0
    a_rst_n = 1'b0; step(1);
    a_rst_n = 1'b1; a_en = 1'b1;
    step(4);
    a_en = 1'b0;
    step(80);
    chk("drop_lat_count", a_lat_n, 2);
    chk("drop_rises", a_rise, 8);
    chk("drop_no_frame_done", a_fd_n, 0);
    chk("drop_oe_idle", a_oe, 1);
    chk("drop_clk_idle", a_clk, 0);
    chk("drop_oe_runs", a_runs, 2);
    chk("drop_oe_len1", a_oe_len[1], 4);
    chk("drop_pix_row", a_row, 1);
    chk("drop_row_addr", a_ra, 0);

    // Reset during SHIFT column 2 (row 1, panel clk high)
    a_en = 1'b1;
    guard = 0;
    while (!(a_row == 1'b1 && a_x == 2'd2 && a_clk) && guard < 100) begin step(1); guard++; end
    chk("midshift_reached", (a_row == 1'b1 && a_x == 2'd2 && a_clk) ? 1 : 0, 1);
    a_rst_n = 1'b0;
    #1;
    chk("mid_rst_clk", a_clk, 0);
    chk("mid_rst_lat", a_lat, 0);
    chk("mid_rst_oe", a_oe, 1);
    chk("mid_rst_row_addr", a_ra, 0);
    chk("mid_rst_pix_row", a_row, 0);
    chk("mid_rst_data", {a_r1, a_g1, a_b1, a_r2, a_g2, a_b2}, 0);
    step(2);
    a_rst_n = 1'b1;
    guard = 0;
    while (a_lat_n < 1 && guard < 100) begin step(1); guard++; end
    chk("restart_first_lat", a_lat_n, 1);
    chk("restart_lat_row", a_lat_row[0], 0);
    chk("restart_rises", a_rise, 4);
    chk("restart_b1_plane0", a_b1v[3:0], 4'b1111);
    chk("restart_r1_plane0", a_r1v[3:0], 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
